// File: rtl/demux1to2_stream.sv
// ---------------------------------------------------------------------------
// demux1to2_stream
//
// Buffered 1-to-2 stream demultiplexer. One valid/ready input stream carries
// a per-word select bit that steers each word into one of two independently
// buffered output channels. Each channel is a small circular FIFO, so a slow
// consumer on one side only stalls the producer when the word at the head of
// the input is aimed at that full channel (head-of-line blocking is accepted).
//
// Parameters
//   WIDTH   data word width in bits (>= 1)
//   DEPTH   per-channel FIFO depth in words (power of two, >= 2)
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous, active-low reset; empties both channels
//   in_data     in   input word
//   in_sel      in   destination channel (0 -> out0, 1 -> out1)
//   in_valid    in   input word present
//   in_ready    out  selected channel has room; word taken when valid & ready
//   out0_data   out  channel 0 head word (0 while empty)
//   out0_valid  out  channel 0 non-empty
//   out0_ready  in   channel 0 consumer takes the head word
//   out1_data   out  channel 1 head word (0 while empty)
//   out1_valid  out  channel 1 non-empty
//   out1_ready  in   channel 1 consumer takes the head word
// ---------------------------------------------------------------------------
module demux1to2_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic                  accept;
    logic [1:0]            push_vec;
    logic [1:0]            pop_vec;
    logic [1:0]            full_vec;
    logic [1:0]            valid_vec;
    logic [1:0]            ready_vec;
    logic [1:0][WIDTH-1:0] head_vec;

    // The full test looks only at the registered count, never at the
    // consumer's ready, so a full channel refuses input even in a cycle where
    // it is also being popped. This keeps in_ready free of any path from the
    // output side.
    assign in_ready  = ~full_vec[in_sel];
    assign accept    = in_valid & in_ready;
    assign push_vec  = {accept & in_sel, accept & ~in_sel};
    assign ready_vec = {out1_ready, out0_ready};
    assign pop_vec   = valid_vec & ready_vec;

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    rd_ptr;
        logic [PW-1:0]    wr_ptr;
        logic [CW-1:0]    count;

        // Pointers wrap naturally because DEPTH is a power of two.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_vec[ch]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop_vec[ch]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push_vec[ch], pop_vec[ch]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        // Storage needs no reset: stale entries are unreachable once the
        // count is cleared, and the head word is masked while empty.
        always_ff @(posedge clk) begin
            if (push_vec[ch]) begin
                mem[wr_ptr] <= in_data;
            end
        end

        assign full_vec[ch]  = (count == FULL_COUNT);
        assign valid_vec[ch] = (count != '0);
        assign head_vec[ch]  = valid_vec[ch] ? mem[rd_ptr] : '0;
    end

    assign out0_valid = valid_vec[0];
    assign out0_data  = head_vec[0];
    assign out1_valid = valid_vec[1];
    assign out1_data  = head_vec[1];

endmodule

// File: tb/tb_demux1to2_stream.sv
// ---------------------------------------------------------------------------
// tb_demux1to2_stream
//
// Directed bench for demux1to2_stream (WIDTH=8, DEPTH=2). Every accepted
// input word is pushed onto the expected queue of its channel; an independent
// monitor compares each channel's head word against its queue whenever the
// channel is valid and pops the queue on a handshake. Directed checks cover
// reset values, latency, backpressure and the no-pop-through rule.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_demux1to2_stream;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;

    int tests    = 0;
    int failures = 0;

    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];

    logic t5Done;

    demux1to2_stream #(.WIDTH(8), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Presents one word and holds it until accepted (bounded). Called at
    // posedge+1, returns at posedge+1 after the accepting edge.
    task automatic applyStimulus(input logic [7:0] data, input logic sel);
        bit accepted;
        accepted = 1'b0;
        in_data  = data;
        in_sel   = sel;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                if (sel) exp1.push_back(data);
                else     exp0.push_back(data);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 8'hEE;
        if (!accepted) begin
            tests++;
            failures++;
            $display("[TB] FAIL push_timeout: word %0h sel %0d got no in_ready, required acceptance", data, sel);
        end
    endtask

    task automatic waitDrain(input string name);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 50 && (exp0.size() != 0 || exp1.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput({name, "_left0"}, 32'(exp0.size()), 32'd0);
        checkOutput({name, "_left1"}, 32'(exp1.size()), 32'd0);
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: head word must match the oldest expected word of
    // that channel whenever the channel is valid; a handshake retires it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out0_valid) begin
                tests++;
                if (exp0.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL ch0_unexpected: got %0h, required no word", out0_data);
                end else begin
                    if (out0_data !== exp0[0]) begin
                        failures++;
                        $display("[TB] FAIL ch0_data: got %0h, required %0h", out0_data, exp0[0]);
                    end
                    if (out0_ready) void'(exp0.pop_front());
                end
            end
            if (out1_valid) begin
                tests++;
                if (exp1.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL ch1_unexpected: got %0h, required no word", out1_data);
                end else begin
                    if (out1_data !== exp1[0]) begin
                        failures++;
                        $display("[TB] FAIL ch1_data: got %0h, required %0h", out1_data, exp1[0]);
                    end
                    if (out1_ready) void'(exp1.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        in_data    = 8'h00;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        t5Done     = 1'b0;

        // Power-on reset values
        #2;
        checkOutput("rst_in_ready",   32'(in_ready),   32'd1);
        checkOutput("rst_out0_valid", 32'(out0_valid), 32'd0);
        checkOutput("rst_out1_valid", 32'(out1_valid), 32'd0);
        checkOutput("rst_out0_data",  32'(out0_data),  32'd0);
        checkOutput("rst_out1_data",  32'(out1_data),  32'd0);
        #10;
        rst_n = 1'b1;
        idleCycle();

        // T2 routing and one-cycle latency
        applyStimulus(8'hA1, 1'b0);
        @(negedge clk);
        checkOutput("t2_lat_out0_valid", 32'(out0_valid), 32'd1);
        checkOutput("t2_lat_out0_data",  32'(out0_data),  32'hA1);
        checkOutput("t2_out1_idle",      32'(out1_valid), 32'd0);
        idleCycle();
        applyStimulus(8'hB2, 1'b1);
        @(negedge clk);
        checkOutput("t2_lat_out1_valid", 32'(out1_valid), 32'd1);
        checkOutput("t2_lat_out1_data",  32'(out1_data),  32'hB2);
        checkOutput("t2_out0_drained",   32'(out0_valid), 32'd0);
        idleCycle();
        applyStimulus(8'hA3, 1'b0);
        @(negedge clk);
        checkOutput("t2_lat_out0_data2", 32'(out0_data),  32'hA3);
        idleCycle();
        // in_valid low with junk data must not push
        in_valid = 1'b0;
        in_data  = 8'h55;
        in_sel   = 1'b0;
        idleCycle();
        idleCycle();
        @(negedge clk);
        checkOutput("t2_novalid_out0", 32'(out0_valid), 32'd0);
        checkOutput("t2_novalid_out1", 32'(out1_valid), 32'd0);
        idleCycle();
        waitDrain("t2");

        // T3 full channel stalls input; head word held; nothing leaks to ch1
        out0_ready = 1'b0;
        applyStimulus(8'hC0, 1'b0);
        applyStimulus(8'hC1, 1'b0);
        fork
            applyStimulus(8'hC2, 1'b0);
            begin
                @(negedge clk);
                checkOutput("t3_full_stall",  32'(in_ready),   32'd0);
                checkOutput("t3_hold_data1",  32'(out0_data),  32'hC0);
                @(negedge clk);
                checkOutput("t3_still_stall", 32'(in_ready),   32'd0);
                checkOutput("t3_hold_data2",  32'(out0_data),  32'hC0);
                checkOutput("t3_hol_out1",    32'(out1_valid), 32'd0);
                @(posedge clk);
                #1;
                out0_ready = 1'b1;
            end
        join
        applyStimulus(8'hD0, 1'b1);
        waitDrain("t3");

        // T4 full plus pop in the same cycle: no pop-through
        out0_ready = 1'b0;
        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'hE1, 1'b0);
        fork
            applyStimulus(8'hE2, 1'b0);
            begin
                out0_ready = 1'b1;
                @(negedge clk);
                checkOutput("t4_no_popthrough", 32'(in_ready), 32'd0);
                @(posedge clk);
                #1;
                out0_ready = 1'b0;
            end
        join
        in_sel = 1'b0;
        @(negedge clk);
        checkOutput("t4_count_two_full", 32'(in_ready),   32'd0);
        checkOutput("t4_head",           32'(out0_data),  32'hE1);
        idleCycle();
        waitDrain("t4");

        // T5 pointer wrap with random consumer backpressure on ch1
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    applyStimulus(8'(i), 1'b1);
                end
                t5Done = 1'b1;
            end
            begin
                while (!t5Done) begin
                    out1_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        waitDrain("t5");

        // T6 push to ch1 while popping ch0
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        applyStimulus(8'hF0, 1'b0);
        fork
            applyStimulus(8'hF1, 1'b1);
            begin
                out0_ready = 1'b1;
                @(posedge clk);
                #1;
                out0_ready = 1'b0;
            end
        join
        @(negedge clk);
        checkOutput("t6_out0_valid", 32'(out0_valid), 32'd0);
        checkOutput("t6_out1_valid", 32'(out1_valid), 32'd1);
        checkOutput("t6_out1_data",  32'(out1_data),  32'hF1);
        idleCycle();
        waitDrain("t6");

        // T1 asynchronous reset mid-stream with two words in each channel
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h20, 1'b1);
        applyStimulus(8'h21, 1'b1);
        in_sel = 1'b0;
        @(negedge clk);
        checkOutput("t1_pre_full0", 32'(in_ready), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t1_in_ready",   32'(in_ready),   32'd1);
        checkOutput("t1_out0_valid", 32'(out0_valid), 32'd0);
        checkOutput("t1_out1_valid", 32'(out1_valid), 32'd0);
        checkOutput("t1_out0_data",  32'(out0_data),  32'd0);
        checkOutput("t1_out1_data",  32'(out1_data),  32'd0);
        exp0.delete();
        exp1.delete();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        idleCycle();
        idleCycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t1_post_quiet0", 32'(out0_valid), 32'd0);
            checkOutput("t1_post_quiet1", 32'(out1_valid), 32'd0);
            idleCycle();
        end
        applyStimulus(8'h99, 1'b1);
        @(negedge clk);
        checkOutput("t1_new_word", 32'(out1_data), 32'h99);
        idleCycle();
        waitDrain("t1");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
